// File: rtl/raster_read_sequencer_if.sv
// ============================================================================
// raster_read_sequencer_if : control, pixel-memory and pixel-stream bundle
// Rev 1.0 - initial release (PatternSel present with RASTER_TEST_PATTERN_EN)
// ============================================================================
`default_nettype none

interface raster_read_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 12
);
  logic              Start;
  logic              Abort;
  logic              Busy;
  logic              Done;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic [WIDTH-1:0]  RdData;
  logic [WIDTH-1:0]  Pixel;
  logic              PixelValid;
  logic              Frame;
  logic              Line;
`ifdef RASTER_TEST_PATTERN_EN
  logic              PatternSel;

  modport master (
    input  Start, Abort, RdData, PatternSel,
    output Busy, Done, RdEn, RdAddr, Pixel, PixelValid, Frame, Line
  );

  modport slave (
    output Start, Abort, RdData, PatternSel,
    input  Busy, Done, RdEn, RdAddr, Pixel, PixelValid, Frame, Line
  );
`else
  modport master (
    input  Start, Abort, RdData,
    output Busy, Done, RdEn, RdAddr, Pixel, PixelValid, Frame, Line
  );

  modport slave (
    output Start, Abort, RdData,
    input  Busy, Done, RdEn, RdAddr, Pixel, PixelValid, Frame, Line
  );
`endif
endinterface

`default_nettype wire

// File: rtl/raster_read_sequencer.sv
// ============================================================================
// raster_read_sequencer : raster-order frame reader with line/frame markers
// Optional macro RASTER_TEST_PATTERN_EN adds a (col ^ row) test pattern.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_read_sequencer #(
  parameter int WIDTH  = 8,
  parameter int COLS   = 64,
  parameter int ROWS   = 64,
  parameter int HBLANK = 4,
  parameter int ADDR_W = 12
) (
  input  logic                    Clk,
  input  logic                    Reset,
  raster_read_sequencer_if.master bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [BLK_W-1:0] c_LAST_BLK = BLK_W'(HBLANK - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_EOF    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t            r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [BLK_W-1:0]  r_blank;
  logic              r_drain;
  logic [ADDR_W-1:0] r_addr;

  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_act;       // read slot this cycle (memory or pattern)
  logic              r_frame_f;
  logic              r_line_f;

  logic              r_s1_frame;
  logic              r_s1_valid;
  logic              r_s1_line;
  logic              r_frame;
  logic              r_valid;
  logic              r_line;
  logic [WIDTH-1:0]  r_pixel;

  logic              w_pat_sel;
  logic [WIDTH-1:0]  w_pix_src;

`ifdef RASTER_TEST_PATTERN_EN
  logic              r_pat_sel;
  logic [WIDTH-1:0]  r_s1_pat;
  logic [WIDTH-1:0]  w_pat_val;

  assign w_pat_val = WIDTH'(r_col) ^ WIDTH'(r_row);
  assign w_pat_sel = r_pat_sel;
  assign w_pix_src = r_pat_sel ? r_s1_pat : bus.RdData;

  // Pattern select is frozen for the whole frame at the accepted Start
  always_ff @(posedge Clk) begin
    if (Reset || bus.Abort) begin
      r_pat_sel <= 1'b0;
      r_s1_pat  <= '0;
    end else begin
      r_s1_pat <= w_pat_val;
      if (r_state == ST_IDLE && bus.Start) begin
        r_pat_sel <= bus.PatternSel;
      end
    end
  end
`else
  assign w_pat_sel = 1'b0;
  assign w_pix_src = bus.RdData;
`endif

  always_ff @(posedge Clk) begin
    if (Reset || bus.Abort) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_blank    <= '0;
      r_drain    <= 1'b0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_act      <= 1'b0;
      r_frame_f  <= 1'b0;
      r_line_f   <= 1'b0;
      r_s1_frame <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_line  <= 1'b0;
      r_frame    <= 1'b0;
      r_valid    <= 1'b0;
      r_line     <= 1'b0;
    end else begin
      // Two-stage flag pipe lines markers up with memory read latency
      r_s1_frame <= r_frame_f;
      r_s1_valid <= r_act;
      r_s1_line  <= r_line_f;
      r_frame    <= r_s1_frame;
      r_valid    <= r_s1_valid;
      r_line     <= r_s1_line;

      r_frame_f  <= 1'b0;
      r_line_f   <= 1'b0;
      r_done     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            r_state   <= ST_SOF;
            r_busy    <= 1'b1;
            r_frame_f <= 1'b1;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
          end
        end
        ST_SOF: begin
          r_state <= ST_ACTIVE;
          r_act   <= 1'b1;
          r_rd_en <= ~w_pat_sel;
        end
        ST_ACTIVE: begin
          if (r_col == c_LAST_COL) begin
            r_col    <= '0;
            r_act    <= 1'b0;
            r_rd_en  <= 1'b0;
            r_line_f <= 1'b1;
            if (r_row == c_LAST_ROW) begin
              r_state <= ST_EOF;
              r_addr  <= '0;
            end else begin
              r_state <= ST_HBLANK;
              r_blank <= '0;
              r_addr  <= r_addr + ADDR_W'(1);
            end
          end else begin
            r_col  <= r_col + COL_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        ST_HBLANK: begin
          if (r_blank == c_LAST_BLK) begin
            r_state <= ST_ACTIVE;
            r_row   <= r_row + ROW_W'(1);
            r_act   <= 1'b1;
            r_rd_en <= ~w_pat_sel;
          end else begin
            r_blank <= r_blank + BLK_W'(1);
          end
        end
        ST_EOF: begin
          r_state <= ST_DRAIN;
          r_drain <= 1'b0;
          r_row   <= '0;
        end
        ST_DRAIN: begin
          if (r_drain) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pixel holds between valid beats and survives Abort; only Reset zeroes it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pixel <= '0;
    end else if (!bus.Abort && r_s1_valid) begin
      r_pixel <= w_pix_src;
    end
  end

  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.RdEn       = r_rd_en;
  assign bus.RdAddr     = r_addr;
  assign bus.Pixel      = r_pixel;
  assign bus.PixelValid = r_valid;
  assign bus.Frame      = r_frame;
  assign bus.Line       = r_line;

endmodule

`default_nettype wire

// File: tb/tb_raster_read_sequencer.sv
// ============================================================================
// tb_raster_read_sequencer : scoreboard bench with timing-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_raster_read_sequencer;

  localparam int WIDTH  = 8;
  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int HBLANK = 2;
  localparam int ADDR_W = 12;
  localparam int PERIOD = 1 + ROWS*COLS + (ROWS-1)*HBLANK + 1 + 2 + 1;
`ifdef RASTER_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  raster_read_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  raster_read_sequencer #(
    .WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .HBLANK(HBLANK), .ADDR_W(ADDR_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge Clk) if (bus.RdEn) bus.RdData <= mem[bus.RdAddr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  evt_t q_pix[$], q_rd[$], q_frame[$], q_line[$], q_done[$];

  int errs   = 0;
  int checks = 0;
  int m_busy_lo = 1, m_busy_hi = 0, m_free_at = 0, m_last_pix = 0;
  bit prev_rst = 1'b1;

  // Expected events of one frame accepted at cycle t0, from the frame timing rules
  function automatic void push_frame(input int t0, input bit pat);
    evt_t e;
    for (int r = 0; r < ROWS; r++) begin
      int row_base;
      row_base = t0 + 2 + r*(COLS + HBLANK);
      for (int c = 0; c < COLS; c++) begin
        int a;
        a = r*COLS + c;
        if (!pat) begin
          e.cyc = row_base + c; e.val = a; q_rd.push_back(e);
        end
        e.cyc = row_base + c + 2;
        e.val = pat ? ((c ^ r) % (1 << WIDTH)) : int'(mem[a]);
        q_pix.push_back(e);
      end
      e.cyc = row_base + COLS + 2; e.val = 0; q_line.push_back(e);
    end
    e.cyc = t0 + 3;      e.val = 0; q_frame.push_back(e);
    e.cyc = t0 + PERIOD; e.val = 0; q_done.push_back(e);
    m_busy_lo = t0 + 1;
    m_busy_hi = t0 + PERIOD - 1;
    m_free_at = t0 + PERIOD + 1;
  endfunction

  function automatic void flush(input int t);
    while (q_pix.size()   > 0 && q_pix[$].cyc   > t) void'(q_pix.pop_back());
    while (q_rd.size()    > 0 && q_rd[$].cyc    > t) void'(q_rd.pop_back());
    while (q_frame.size() > 0 && q_frame[$].cyc > t) void'(q_frame.pop_back());
    while (q_line.size()  > 0 && q_line[$].cyc  > t) void'(q_line.pop_back());
    while (q_done.size()  > 0 && q_done[$].cyc  > t) void'(q_done.pop_back());
    if (m_busy_hi > t) m_busy_hi = t;
    m_free_at = t + 1;
  endfunction

  task automatic cycle(input bit s, input bit a, input bit r, input bit p);
    @(posedge Clk);
    #1;
    bus.Start = s;
    bus.Abort = a;
    Reset     = r;
`ifdef RASTER_TEST_PATTERN_EN
    bus.PatternSel = p;
`endif
    if (r || a) flush(cyc);
    else if (s && cyc >= m_free_at) push_frame(cyc, PAT_EN && p);
  endtask

  task automatic chk(input string nm, input bit seen, input int act, input evt_t f,
                     output bit pop);
    bit have, exp;
    have = (f.cyc >= 0);
    pop  = 1'b0;
    checks++;
    if (have && f.cyc < cyc) begin
      errs++;
      $display("FAIL %s: event due at cycle %0d not seen (now %0d)", nm, f.cyc, cyc);
      pop = 1'b1;
    end else begin
      exp = have && (f.cyc == cyc);
      if (seen != exp) begin
        errs++;
        $display("FAIL %s @%0d: asserted=%0b required=%0b", nm, cyc, seen, exp);
      end else if (seen && act != f.val) begin
        errs++;
        $display("FAIL %s @%0d: value=%0d required=%0d", nm, cyc, act, f.val);
      end
      pop = exp;
    end
  endtask

  always @(negedge Clk) begin
    if (cyc >= 1) begin
      evt_t f;
      bit   pop;
      bit   exp_busy;
      if (prev_rst) m_last_pix = 0;

      f.cyc = -1; f.val = 0; if (q_pix.size() > 0) f = q_pix[0];
      chk("pixel", bus.PixelValid, int'(bus.Pixel), f, pop);
      if (pop) begin
        if (f.cyc == cyc) m_last_pix = f.val;
        void'(q_pix.pop_front());
      end

      f.cyc = -1; f.val = 0; if (q_rd.size() > 0) f = q_rd[0];
      chk("rdaddr", bus.RdEn, int'(bus.RdAddr), f, pop);
      if (pop) void'(q_rd.pop_front());

      f.cyc = -1; f.val = 0; if (q_frame.size() > 0) f = q_frame[0];
      chk("frame", bus.Frame, 0, f, pop);
      if (pop) void'(q_frame.pop_front());

      f.cyc = -1; f.val = 0; if (q_line.size() > 0) f = q_line[0];
      chk("line", bus.Line, 0, f, pop);
      if (pop) void'(q_line.pop_front());

      f.cyc = -1; f.val = 0; if (q_done.size() > 0) f = q_done[0];
      chk("done", bus.Done, 0, f, pop);
      if (pop) void'(q_done.pop_front());

      if (!bus.PixelValid) begin
        checks++;
        if (int'(bus.Pixel) != m_last_pix) begin
          errs++;
          $display("FAIL pixel_hold @%0d: value=%0d required=%0d", cyc, bus.Pixel, m_last_pix);
        end
      end

      exp_busy = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
      checks++;
      if (bus.Busy !== exp_busy) begin
        errs++;
        $display("FAIL busy @%0d: value=%0b required=%0b", cyc, bus.Busy, exp_busy);
      end

      if (!exp_busy) begin
        checks++;
        if (bus.RdAddr !== '0) begin
          errs++;
          $display("FAIL idle_addr @%0d: value=%0d required=0", cyc, bus.RdAddr);
        end
      end
    end
    prev_rst = Reset;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
`ifdef RASTER_TEST_PATTERN_EN
    bus.PatternSel = 1'b0;
`endif
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = WIDTH'($urandom);

    repeat (3)  cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Single frame; Start again at +5 and +21 is ignored, +22 starts a new frame
    for (int k = 0; k < 48; k++)
      cycle(k == 0 || k == 5 || k == 21 || k == 22, 1'b0, 1'b0, 1'b0);

    // Abort mid-frame, then a clean restart
    for (int k = 0; k < 40; k++)
      cycle(k == 0 || k == 12, k == 9, 1'b0, 1'b0);

    // Start together with Abort while idle
    for (int k = 0; k < 8; k++)
      cycle(k == 0, k == 0, 1'b0, 1'b0);

    // Reset in the middle of a frame
    for (int k = 0; k < 30; k++)
      cycle(k == 0, 1'b0, k == 6, 1'b0);

    // Frame with pattern select raised (plain memory frame in the default build)
    for (int k = 0; k < 26; k++)
      cycle(k == 0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 299) == 0, 1'($urandom));

    repeat (30) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    checks++; if (q_pix.size()   != 0) begin errs++; $display("FAIL pix_left: %0d required=0",   q_pix.size());   end
    checks++; if (q_rd.size()    != 0) begin errs++; $display("FAIL rd_left: %0d required=0",    q_rd.size());    end
    checks++; if (q_frame.size() != 0) begin errs++; $display("FAIL frame_left: %0d required=0", q_frame.size()); end
    checks++; if (q_line.size()  != 0) begin errs++; $display("FAIL line_left: %0d required=0",  q_line.size());  end
    checks++; if (q_done.size()  != 0) begin errs++; $display("FAIL done_left: %0d required=0",  q_done.size());  end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/raster_read_sequencer.md
Name: raster_read_sequencer

Overview:
- Frame-level controller for the pixel stream that feeds the downstream output handler.
- On Start, it reads one COLS x ROWS image from a synchronous pixel memory in raster order.
- It emits Pixel/PixelValid with Frame and Line markers, inserting horizontal blanking between rows.
- It reports Busy/Done, and it can be aborted mid-frame.

Parameters:
- WIDTH, 8, pixel bit width.
- COLS, 64, pixels per row (>=2).
- ROWS, 64, rows per frame (>=2).
- HBLANK, 4, blank cycles between rows (>=1).
- ADDR_W, 12, memory address width; COLS*ROWS <= 2**ADDR_W.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous active-high reset.
- Start  in  1  frame request; sampled only in IDLE.
- Abort  in  1  cancel current frame.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle frame-complete pulse.
- RdEn  out  1  memory read enable.
- RdAddr  out  ADDR_W  linear read address, row*COLS+col.
- RdData  in  WIDTH  memory data, valid the cycle after RdEn.
- Pixel  out  WIDTH  pixel value.
- PixelValid  out  1  Pixel is valid this cycle.
- Frame  out  1  one-cycle start-of-frame marker.
- Line  out  1  one-cycle end-of-row marker.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high.
- Reset: state IDLE, col/row/address counters 0, pipeline cleared. All outputs 0.
- States:
  - IDLE: Start moves to SOF.
  - SOF: 1 cycle; raises the internal frame flag. Next state ACTIVE.
  - ACTIVE: COLS cycles. RdEn=1 with RdAddr incrementing by 1 each cycle. After the last col, go to HBLANK if row<ROWS-1, else EOF.
  - HBLANK: HBLANK cycles. First cycle raises the internal line flag. Then row++ and back to ACTIVE.
  - EOF: 1 cycle; raises the internal line flag for the last row.
  - DRAIN: 2 cycles.
  - DONE: 1 cycle. Done=1, then IDLE.
- Pipeline:
  - Internal frame/valid/line flags pass through a 2-stage register pipe, so they align with returned data.
  - Pixel is RdData registered once.
  - Latency RdEn -> PixelValid/Pixel is 2 cycles; Frame precedes the first pixel by 1 cycle.
- Line appears on the cycle immediately after the last pixel of each row. Exactly ROWS Line pulses per frame.
- When PixelValid=0, Pixel holds its previous value.
- Busy=1 in SOF, ACTIVE, HBLANK, EOF and DRAIN. Busy=0 in IDLE and DONE.
- Start outside IDLE is ignored, including in the DONE cycle.
- Abort (any state) at edge n: at n+1 the state is IDLE, counters are 0, and both pipe stages are cleared. RdEn, PixelValid, Frame and Line are 0 from that cycle on. No Done is issued.
- Abort and Start in the same cycle in IDLE: Abort wins and the block stays IDLE.
- Reset mid-frame behaves like Abort, and additionally zeroes Pixel.
- RdAddr wraps only via counter reset at frame start; it never exceeds COLS*ROWS-1.
- Frame period from Start: 1 + ROWS*COLS + (ROWS-1)*HBLANK + 1 + 2 + 1 cycles to Done.

Optional Feature:
- Macro: RASTER_TEST_PATTERN_EN.
- Defined:
  - Adds input port PatternSel (1 bit), sampled at Start and held for the frame.
  - When 1: RdEn stays 0, and Pixel = (col ^ row) truncated to WIDTH, through the same 2-stage timing.
  - When 0: normal memory read.
- Undefined: no PatternSel port; the block always reads memory.

Test Plan:
All scenarios use COLS=4, ROWS=3, HBLANK=2, and memory returning data=address. Cycle 0 is the cycle Start is high.
- Reset held 3 cycles, then idle 10 cycles -> all outputs 0; RdEn never asserted.
- Single frame ->
  - Frame at cycle 3.
  - PixelValid at 4-7 with Pixel 0,1,2,3; Line at 8.
  - Row 1: pixels 4-7 at cycles 10-13; Line at 14.
  - Row 2: pixels 8-11 at 16-19; Line at 20.
  - Done at 21; Busy high cycles 1-20.
  - 12 PixelValid and 3 Line pulses total.
- Start re-asserted at cycles 5 and 21 -> ignored; no second Frame. Start at 22 -> new Frame at 25.
- Abort at cycle 9 ->
  - IDLE from cycle 10; RdEn, PixelValid and Line are 0 from cycle 10.
  - Done never pulses.
  - A following Start at 12 produces a clean frame, with Frame at 15 and first Pixel 0 at 16.
- Start and Abort together in IDLE -> Busy stays 0 and no Frame. Reset asserted at cycle 6 mid-frame -> all outputs 0 from cycle 7.
- RASTER_TEST_PATTERN_EN with PatternSel=1 -> RdEn always 0. Row 1 Pixel sequence 1,0,3,2; row 2 Pixel sequence 2,3,0,1. Line and Done timing is identical to the single-frame case.
